// File: rtl/rot_pkg.sv
//------------------------------------------------------------------------------
// rot_pkg : shared widths and FSM encoding for the rotate blocks. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rot_pkg;

  // Widths are shared with the rotate-right shifter so the pair always matches.
  localparam int unsigned ROT_DATA_W = 8;
  localparam int unsigned ROT_AMT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } rot_state_t;

endpackage

`default_nettype wire

// File: rtl/rotate_left_seq.sv
//------------------------------------------------------------------------------
// rotate_left_seq : multi-cycle left rotator, one bit position per clock.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rotate_left_seq
  import rot_pkg::*;
#(
  parameter int DATA_W = ROT_DATA_W,
  parameter int AMT_W  = ROT_AMT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  output logic              ready,
  output logic              done_tick,
  output logic [DATA_W-1:0] y
);

  rot_state_t        state_reg;
  logic [DATA_W-1:0] data_reg;
  logic [AMT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] y_reg;
  logic [DATA_W-1:0] rot1;

  assign rot1 = {data_reg[DATA_W-2:0], data_reg[DATA_W-1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      cnt_reg   <= '0;
      y_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            data_reg <= a;
            cnt_reg  <= amt;
            if (amt == '0) begin
              // Zero rotation skips ROT, so the result is captured here.
              y_reg     <= a;
              state_reg <= DONE;
            end else begin
              state_reg <= ROT;
            end
          end
        end
        ROT: begin
          data_reg <= rot1;
          cnt_reg  <= cnt_reg - AMT_W'(1);
          if (cnt_reg == AMT_W'(1)) begin
            y_reg     <= rot1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready     = (state_reg == IDLE);
  assign done_tick = (state_reg == DONE);
  assign y         = y_reg;

endmodule

`default_nettype wire

// File: doc/rotate_left_seq.md
# rotate_left_seq

Multi-cycle left rotator: accepts a data word and a rotate amount on a start handshake, rotates left one bit position per clock, then presents the registered result with a one-cycle done pulse. It is the inverse of the team's combinational rotate-right barrel shifter. Rotating a word right by k and then through this block by the same k returns the original word. The block sits behind control FSMs where area matters more than latency.

## Interface
- `DATA_W`: default 8. Data width; must be a power of 2, at least 2.
- `AMT_W`: default 3. Amount width; must equal log2(`DATA_W`).
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Request; sampled only while `ready`=1.
- `a`: input, `DATA_W` bits. Operand; sampled with `start`.
- `amt`: input, `AMT_W` bits. Left-rotate amount, 0..`DATA_W`-1; sampled with `start`.
- `ready`: output, 1 bit. High when idle and able to accept `start`.
- `done_tick`: output, 1 bit. One-cycle pulse; `y` is valid in this cycle.
- `y`: output, `DATA_W` bits. Result register; holds its value until the next `done_tick`.

## Operation
- Internal state:
  - `data_reg` (`DATA_W` bits)
  - `cnt_reg` (`AMT_W` bits)
  - `y_reg` (drives `y`)
  - `state_reg`
- FSM states:
  - `IDLE`:
    - `ready`=1.
    - On `start`: `data_reg`<=`a`, `cnt_reg`<=`amt`.
    - Next state is `DONE` if `amt`==0, else `ROT`.
  - `ROT`:
    - Each cycle: `data_reg`<={`data_reg`[`DATA_W`-2:0], `data_reg`[`DATA_W`-1]} and `cnt_reg`<=`cnt_reg`-1.
    - When `cnt_reg`==1 this cycle, next state is `DONE`.
  - `DONE`:
    - `done_tick`=1 and `y` shows the final `data_reg`.
    - `y_reg` is loaded on the transition into `DONE`.
    - Next state is `IDLE` unconditionally.
- `start` outside `IDLE` is ignored; no queuing, no error flag.
- `a` and `amt` are don't-care except in the cycle `start` is accepted.
- `cnt_reg` never wraps: `ROT` is entered only with `cnt_reg`≥1 and left when it reaches 0.
- Result is exactly `y` = `a` rotated left by `amt` mod `DATA_W`, i.e. {a[DATA_W-1-amt:0], a[DATA_W-1:DATA_W-amt]}.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - `state_reg`=`IDLE`
  - `ready`=1
  - `done_tick`=0
  - `y`=0
  - `data_reg`=0
  - `cnt_reg`=0
- Latency: with `start` accepted at edge 0, `done_tick` is high in cycle `amt`+1.
  - `amt`=0: 1 cycle.
  - `amt`=7 with `DATA_W`=8: 8 cycles.
- `ready` returns high the cycle after `done_tick`.
- Throughput: one operation per `amt`+2 cycles.
- `ready` and `done_tick` are Moore outputs decoded from `state_reg`; no combinational path from inputs to outputs.
- Reset asserted mid-operation:
  - Aborts immediately; no `done_tick` is issued.
  - `y` clears to 0.
  - Block is ready on the first edge after `reset_n` deasserts.
- `start` held high continuously: a new operation is accepted on each `IDLE` cycle, re-sampling `a` and `amt` each time.

## Structure
- Shared package `rot_pkg` holds:
  - State encoding constants `IDLE`, `ROT`, `DONE` (2-bit).
  - Default `DATA_W`/`AMT_W` constants, shared with the rotate-right shifter so widths stay matched.
- Single module: state/data/counter registers plus next-state logic.
- No sub-module is warranted; the one-bit rotate is a single concatenation.

## Test plan
- `a`=8'h81, `amt`=1 -> `done_tick` 2 cycles after `start`, `y`=8'h03; `ready` low for cycles 1-2.
- `a`=8'hA5, `amt`=0 -> `done_tick` 1 cycle after `start`, `y`=8'hA5.
- `a`=8'h01, `amt`=7 -> `done_tick` in cycle 8, `y`=8'h80; pulse `start` with `a`=8'hFF during cycles 1-7 -> ignored, result unchanged.
- Exhaustive inverse check: all 256 `a` × 8 `amt`, feed rotate-right(`a`,`amt`) -> `y`==`a` every time.
- Assert `reset_n`=0 in cycle 3 of an `amt`=5 operation -> outputs immediately `ready`=1, `done_tick`=0, `y`=0; no late pulse. Next `start` (`a`=8'h0F, `amt`=4) -> `y`=8'hF0.
- Back-to-back operations with `start` held high -> every `done_tick` exactly one cycle wide, separated by `amt`+2 cycles.
